uart_tx_fifo_drain: RTL

- UART transmitter that sits at the read end of the byte FIFO.
- Watches the FIFO `empty` flag, pops one byte per frame, and serialises it as 8N1 on `tx`, LSB first.
- Pairs with the FIFO's first-word-fall-through read port: `pop_data` is valid whenever `empty` is low.
- Feeds the PC-side serial link of the plotter controller.

---
 rtl/uart_tx_fifo_drain.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - 8N1 UART transmitter draining a first-word-fall-through FIFO
// Pops one byte per frame and can launch the next frame in the last stop cycle.
module uart_tx_fifo_drain #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(DIV - 1);
  localparam logic [BW-1:0] BCNT_PRE  = BW'(DIV - 2);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_tx_fifo_drain: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state;
  logic [BW-1:0]         bcnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  bcnt_end;
  logic                  can_launch;

  assign bcnt_end   = (bcnt == BCNT_LAST);
  assign shift_next = shift >> 1;

  // A launch is only possible from IDLE or from the final stop cycle.
  assign can_launch = ~reset & tx_en & ~fifo_empty;
  assign fifo_pop   = can_launch & ((state == IDLE) | ((state == STOP) & bcnt_end));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bcnt    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fifo_pop) begin
            shift   <= fifo_data;
            bcnt    <= '0;
            state   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end

        START: begin
          if (bcnt_end) begin
            bcnt    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end

        DATA: begin
          if (bcnt_end) begin
            bcnt  <= '0;
            shift <= shift_next;
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift_next[0];
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end

        STOP: begin
          if (bcnt_end) begin
            bcnt <= '0;
            if (fifo_pop) begin
              shift <= fifo_data;
              state <= START;
              tx    <= 1'b0;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
            // Registered so the pulse lands exactly on the last stop cycle.
            if (bcnt == BCNT_PRE) tx_done <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          bcnt    <= '0;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
